// File: rtl/gat_bram_load_bridge_if.sv
// Bundle of NUM_CH BRAM-style ports (enable, write-enable, address, data).
// The same type is used on the host side (byte address) and the BRAM side (word address).
interface gat_bram_load_bridge_if #(
    parameter int NUM_CH = 4,
    parameter int DW     = 32,
    parameter int AW     = 20
);
    logic [NUM_CH*DW-1:0] din;
    logic [NUM_CH-1:0]    ena;
    logic [NUM_CH-1:0]    wea;
    logic [NUM_CH*AW-1:0] addra;

    modport master (output din, ena, wea, addra);
    modport slave  (input  din, ena, wea, addra);
endinterface

// File: rtl/gat_bram_load_bridge.sv
// Host-to-BRAM load bridge: counts aligned in-range writes per channel against an armed expect count.
// Optional idle watchdog in LOAD is compiled in with `define GAT_LOAD_TIMEOUT_EN.
//
// state | meaning
// IDLE  | nothing armed; writes are rejected and flagged, reads pass through
// LOAD  | armed; accepted writes are forwarded and counted per channel
// DONE  | every channel reached its expect count; writes rejected, reads pass through
module gat_bram_load_bridge #(
    parameter int TOP_WIDTH   = 32,
    parameter int NUM_CH      = 4,
    parameter int ADDR_W      = 18,
    parameter int CNT_W       = 20,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                      clk,
    input  logic                      rst,
    gat_bram_load_bridge_if.slave     s_port,
    gat_bram_load_bridge_if.master    m_port,
    input  logic [NUM_CH*CNT_W-1:0]   cfg_expect,
    input  logic                      cfg_start,
    output logic [NUM_CH-1:0]         load_done,
    output logic                      all_done,
    output logic [NUM_CH-1:0]         err_flags,
    output logic                      busy
);
    localparam int HAW   = ADDR_W + 2;
    localparam int CMP_W = (ADDR_W > CNT_W) ? ADDR_W : CNT_W;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t                    state;
    logic [CNT_W-1:0]          expect_q [NUM_CH];
    logic [CNT_W-1:0]          cnt_q    [NUM_CH];
    logic [NUM_CH*TOP_WIDTH-1:0] m_din_q;
    logic [NUM_CH*ADDR_W-1:0]  m_addra_q;
    logic [NUM_CH-1:0]         m_ena_q;
    logic [NUM_CH-1:0]         m_wea_q;

    logic [HAW-1:0]            host_addr [NUM_CH];
    logic [CMP_W-1:0]          word_ext  [NUM_CH];
    logic [NUM_CH-1:0]         wr_req;
    logic [NUM_CH-1:0]         rd_req;
    logic [NUM_CH-1:0]         wr_acc;
    logic [NUM_CH-1:0]         wr_bad;
    logic                      wd_fire;

    assign m_port.din   = m_din_q;
    assign m_port.addra = m_addra_q;
    assign m_port.ena   = m_ena_q;
    assign m_port.wea   = m_wea_q;

    // A write coinciding with cfg_start is silently discarded: the restart wins.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            host_addr[i] = s_port.addra[i*HAW +: HAW];
            word_ext[i]  = CMP_W'(host_addr[i][HAW-1:2]);
            wr_req[i]    = s_port.ena[i] & s_port.wea[i];
            rd_req[i]    = s_port.ena[i] & ~s_port.wea[i];
            wr_acc[i]    = 1'b0;
            wr_bad[i]    = 1'b0;
            if (wr_req[i] && !cfg_start) begin
                if (state == LOAD && host_addr[i][1:0] == 2'b00 &&
                    word_ext[i] < CMP_W'(expect_q[i]) && !load_done[i])
                    wr_acc[i] = 1'b1;
                else
                    wr_bad[i] = 1'b1;
            end
        end
    end

`ifdef GAT_LOAD_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_q;

    assign wd_fire = (state == LOAD) && (wr_acc == '0) && (wd_q == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || cfg_start || state != LOAD || wr_acc != '0)
            wd_q <= '0;
        else
            wd_q <= wd_q + 1'b1;
    end
`else
    assign wd_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            all_done  <= 1'b0;
            load_done <= '0;
            err_flags <= '0;
            m_din_q   <= '0;
            m_addra_q <= '0;
            m_ena_q   <= '0;
            m_wea_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]    <= '0;
                expect_q[i] <= '0;
            end
        end else begin
            m_ena_q <= wr_acc | rd_req;
            m_wea_q <= wr_acc;
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_acc[i] || rd_req[i]) begin
                    m_din_q[i*TOP_WIDTH +: TOP_WIDTH] <= s_port.din[i*TOP_WIDTH +: TOP_WIDTH];
                    m_addra_q[i*ADDR_W +: ADDR_W]     <= host_addr[i][HAW-1:2];
                end
            end

            if (cfg_start) begin
                state     <= LOAD;
                busy      <= 1'b1;
                all_done  <= 1'b0;
                load_done <= '0;
                err_flags <= '0;
                for (int i = 0; i < NUM_CH; i++) begin
                    cnt_q[i]    <= '0;
                    expect_q[i] <= cfg_expect[i*CNT_W +: CNT_W];
                end
            end else begin
                err_flags <= err_flags | wr_bad;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (wr_acc[i] && cnt_q[i] != expect_q[i])
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                end
                if (state == LOAD) begin
                    // completion is registered one cycle after the count lands on expect
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (cnt_q[i] == expect_q[i])
                            load_done[i] <= 1'b1;
                    end
                    if (&load_done) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        all_done <= 1'b1;
                    end else if (wd_fire) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        err_flags <= err_flags | wr_bad | ~load_done;
                    end
                end
            end
        end
    end
endmodule

// File: doc/gat_bram_load_bridge.md
GAT_BRAM_LOAD_BRIDGE -- requirements
Module: gat_bram_load_bridge

Interface
REQ-001 SHALL have parameter TOP_WIDTH, default 32: width of each host-side data word.
REQ-002 SHALL have parameter NUM_CH, default 4: number of independent BRAM load channels.
REQ-003 SHALL have parameter ADDR_W, default 18: word-address width per channel; the host byte address is ADDR_W+2 bits.
REQ-004 SHALL have parameter CNT_W, default 20: width of per-channel expected-count and write counters.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 65535: idle-cycle limit for the watchdog in REQ-030.
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 s_din  in  NUM_CH*TOP_WIDTH  host write data; channel i in slice i.
REQ-009 s_ena / s_wea  in  NUM_CH each  host enable and write-enable per channel.
REQ-010 s_addra  in  NUM_CH*(ADDR_W+2)  host byte address per channel.
REQ-011 cfg_expect  in  NUM_CH*CNT_W  expected write count per channel, latched on cfg_start.
REQ-012 cfg_start  in  1  single-cycle pulse that arms a load.
REQ-013 m_din  out  NUM_CH*TOP_WIDTH; m_ena, m_wea  out  NUM_CH; m_addra  out  NUM_CH*ADDR_W: registered BRAM-side port, word address.
REQ-014 load_done  out  NUM_CH  per-channel completion flags.
REQ-015 all_done  out  1  all channels complete.
REQ-016 err_flags  out  NUM_CH  sticky per-channel error flags.
REQ-017 busy  out  1  high while in LOAD.

Function
REQ-018 FSM states: IDLE, LOAD, DONE; IDLE->LOAD and DONE->LOAD on cfg_start; LOAD->DONE when all load_done bits are 1.
REQ-019 On cfg_start: latch cfg_expect, clear all counters, load_done, and err_flags; cfg_start in LOAD restarts identically.
REQ-020 A write (s_ena&s_wea) accepted in LOAD is forwarded with exactly 1 cycle latency: m_addra = s_addra[ADDR_W+1:2], m_din = s_din, m_ena = m_wea = 1.
REQ-021 An accepted write increments that channel's counter by 1; duplicate addresses are counted again.
REQ-022 load_done[i] rises in the cycle after the counter reaches expect[i]; the counter saturates at expect[i].
REQ-023 A channel with expect = 0 asserts load_done in the cycle after cfg_start.
REQ-024 A write is dropped (not forwarded, not counted) and sets err_flags[i] if any of these hold: s_addra[1:0] != 0, word address >= expect[i], load_done[i] already set, or the FSM is not in LOAD.
REQ-025 A read (s_ena & !s_wea) is forwarded in every state with 1 cycle latency, m_wea = 0, and is not counted.
REQ-026 When cfg_start coincides with a write, cfg_start has priority: counters are cleared and that write is dropped without setting an error.
REQ-027 Channels are fully independent: simultaneous writes on all NUM_CH channels in one cycle are each accepted.
REQ-028 all_done = 1 exactly while in DONE; busy = 1 exactly while in LOAD.

Reset
REQ-029 While rst = 1 at a clock edge: state = IDLE, and all outputs, counters, latched expects, load_done, and err_flags = 0; rst mid-LOAD aborts the load with no further BRAM writes.

Configuration
REQ-030 GAT_LOAD_TIMEOUT_EN defined: in LOAD, a watchdog counts cycles with no accepted write on any channel; on reaching TIMEOUT_CYC it sets err_flags for every channel without load_done and returns to IDLE.
REQ-031 GAT_LOAD_TIMEOUT_EN undefined: no watchdog logic exists, and LOAD persists until all channels complete or rst.

Verification
REQ-032 NUM_CH=4, expect={4,4,4,4}, cfg_start, then 4 writes per channel at byte addresses 0,4,8,12 -> m_addra 0..3 one cycle later, load_done=4'hF, all_done=1 the next cycle.
REQ-033 Ch0 write to byte address 6, then to 0x40 with expect=4 -> both writes dropped, err_flags[0]=1, counter stays 0.
REQ-034 expect={0,2,2,2} -> load_done[0]=1 the cycle after cfg_start; a write to ch0 sets err_flags[0].
REQ-035 cfg_start coincident with a ch1 write mid-LOAD -> counters cleared, no m_ena[1], err_flags=0; rst asserted mid-LOAD -> all outputs 0 next cycle.
REQ-036 With GAT_LOAD_TIMEOUT_EN, TIMEOUT_CYC=16, no writes after cfg_start -> after 16 cycles, state IDLE and err_flags=4'hF; without the macro, busy stays 1.
